// File: rtl/muldiv_unit_pkg.sv
// Shared types for the multiply/divide unit: op and state encodings, the HI/LO
// result pairing, and small arithmetic helpers used by the unit and its div core.
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } muldiv_state_t;

  localparam int DIV_ITERS = 32;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_w_t;

  function automatic logic is_div_op(input muldiv_op_t o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  // Two's-complement magnitude; 32'h80000000 maps to itself, which reads correctly as unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? (~x + 32'd1) : x;
  endfunction

  function automatic hilo_w_t mul64(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y);
    logic        sgn;
    logic [63:0] ex;
    logic [63:0] ey;
    logic [63:0] p;
    sgn = (o == OP_MULT);
    ex  = {{32{sgn & x[31]}}, x};
    ey  = {{32{sgn & y[31]}}, y};
    p   = ex * ey;
    return p;
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Radix-2 restoring divider on unsigned magnitudes: one quotient bit per step,
// DIV_ITERS steps after a load. Sign fix-up and special cases live in the parent.
module muldiv_div_core
  import muldiv_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        last
);

  logic [31:0] rem_reg;
  logic [31:0] quo_reg;
  logic [31:0] dvs_reg;
  logic [5:0]  cnt_reg;
  logic [33:0] trial;

  // Extra headroom bit so the borrow is unambiguous even when divisor is zero.
  assign trial = {1'b0, rem_reg, quo_reg[31]} - {2'b00, dvs_reg};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_reg <= '0;
      quo_reg <= '0;
      dvs_reg <= '0;
      cnt_reg <= '0;
    end else if (load) begin
      rem_reg <= '0;
      quo_reg <= dividend;
      dvs_reg <= divisor;
      cnt_reg <= '0;
    end else if (step) begin
      if (trial[33]) begin
        rem_reg <= {rem_reg[30:0], quo_reg[31]};
        quo_reg <= {quo_reg[30:0], 1'b0};
      end else begin
        rem_reg <= trial[31:0];
        quo_reg <= {quo_reg[30:0], 1'b1};
      end
      cnt_reg <= cnt_reg + 6'd1;
    end
  end

  assign quotient  = quo_reg;
  assign remainder = rem_reg;
  assign last      = (cnt_reg == 6'(DIV_ITERS - 1));

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit producing HI/LO for the exec stage.
// Optional MULDIV_EARLY_OUT_EN: trivial divides (b==0 or |a|<|b|) finish the cycle after start.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int MUL_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  muldiv_op_t  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ack,
  input  logic        flush,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        mult_ok,
  output logic        busy
);

  muldiv_state_t state_reg;
  muldiv_op_t    op_reg;
  logic [31:0]   a_reg;
  logic [31:0]   b_reg;
  hilo_w_t       hilo_reg;
  logic [2:0]    mul_cnt_reg;

  hilo_w_t     mul_comb;
  hilo_w_t     mul_res;
  hilo_w_t     fix_res;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_last;
  logic        div_load;
  logic        in_signed;

  assign in_signed = (op == OP_DIV);
  assign div_load  = (state_reg == S_IDLE) && start && !flush && is_div_op(op);

  muldiv_div_core u_div_core (
    .clk       (clk),
    .reset     (reset),
    .load      (div_load),
    .step      (state_reg == S_DIV),
    .dividend  (mag32(a, in_signed)),
    .divisor   (mag32(b, in_signed)),
    .quotient  (quotient),
    .remainder (remainder),
    .last      (div_last)
  );

  // Product is computed from the captured operands and retimed through MUL_STAGES-1
  // registers; the HI/LO register provides the final stage.
  assign mul_comb = mul64(op_reg, a_reg, b_reg);

  generate
    if (MUL_STAGES == 1) begin : g_mul_direct
      assign mul_res = mul_comb;
    end else begin : g_mul_pipe
      hilo_w_t pipe_reg [MUL_STAGES-1];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < MUL_STAGES - 1; i++) pipe_reg[i] <= '0;
        end else begin
          pipe_reg[0] <= mul_comb;
          for (int i = 1; i < MUL_STAGES - 1; i++) pipe_reg[i] <= pipe_reg[i-1];
        end
      end
      assign mul_res = pipe_reg[MUL_STAGES-2];
    end
  endgenerate

  always_comb begin
    fix_res = '0;
    if (b_reg == 32'd0) begin
      fix_res.hi = a_reg;
      fix_res.lo = 32'hFFFF_FFFF;
    end else begin
      fix_res.lo = (op_reg == OP_DIV && (a_reg[31] ^ b_reg[31])) ? (~quotient + 32'd1) : quotient;
      fix_res.hi = (op_reg == OP_DIV && a_reg[31]) ? (~remainder + 32'd1) : remainder;
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic early_out;
  assign early_out = is_div_op(op) && ((b == 32'd0) || (mag32(a, in_signed) < mag32(b, in_signed)));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      op_reg      <= OP_MULT;
      a_reg       <= '0;
      b_reg       <= '0;
      hilo_reg    <= '0;
      mul_cnt_reg <= '0;
    end else if (flush) begin
      state_reg <= S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            op_reg      <= op;
            a_reg       <= a;
            b_reg       <= b;
            mul_cnt_reg <= '0;
            if (!is_div_op(op)) begin
              state_reg <= S_MUL;
            end else begin
`ifdef MULDIV_EARLY_OUT_EN
              if (early_out) begin
                state_reg   <= S_DONE;
                hilo_reg.hi <= a;
                hilo_reg.lo <= (b == 32'd0) ? 32'hFFFF_FFFF : 32'd0;
              end else begin
                state_reg <= S_DIV;
              end
`else
              state_reg <= S_DIV;
`endif
            end
          end
        end
        S_MUL: begin
          if (mul_cnt_reg == 3'(MUL_STAGES - 1)) begin
            state_reg <= S_DONE;
            hilo_reg  <= mul_res;
          end else begin
            mul_cnt_reg <= mul_cnt_reg + 3'd1;
          end
        end
        S_DIV: begin
          if (div_last) state_reg <= S_FIX;
        end
        S_FIX: begin
          state_reg <= S_DONE;
          hilo_reg  <= fix_res;
        end
        S_DONE: begin
          if (ack) state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign hi      = hilo_reg.hi;
  assign lo      = hilo_reg.lo;
  assign mult_ok = (state_reg == S_DONE);
  assign busy    = (state_reg == S_MUL) || (state_reg == S_DIV) || (state_reg == S_FIX);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, stall/flush/reset scenarios
// and randomized operations against a plain-arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int MS = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  muldiv_op_t  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        ack;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        mult_ok;
  logic        busy;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] last_exp = '0;

  always #5 clk = ~clk;

  muldiv_unit #(.MUL_STAGES(MS)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .ack     (ack),
    .flush   (flush),
    .hi      (hi),
    .lo      (lo),
    .mult_ok (mult_ok),
    .busy    (busy)
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {hi, lo} computed straight from MIPS arithmetic rules.
  function automatic logic [63:0] model(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y);
    longint          sx;
    longint          sy;
    longint unsigned ux;
    longint unsigned uy;
    longint          q;
    longint          r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = 64'(x);
    uy = 64'(y);
    case (o)
      OP_MULT:  return 64'(sx * sy);
      OP_MULTU: return 64'(ux * uy);
      OP_DIV: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {32'(x % y), 32'(x / y)};
      end
    endcase
  endfunction

  function automatic int model_latency(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y);
    longint ax;
    longint ay;
    if (o == OP_MULT || o == OP_MULTU) return MS + 1;
`ifdef MULDIV_EARLY_OUT_EN
    ax = (o == OP_DIV) ? longint'($signed(x)) : longint'(x);
    ay = (o == OP_DIV) ? longint'($signed(y)) : longint'(y);
    if (ax < 0) ax = -ax;
    if (ay < 0) ay = -ay;
    if (y == 0 || ax < ay) return 1;
`else
    ax = 0;
    ay = 0;
`endif
    return 34 + 32'(ax * 0) + 32'(ay * 0);
  endfunction

  // Issue one op, wait (bounded) for mult_ok, check latency and results, then ack.
  task automatic run_op(input string tag, input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] exp;
    int          lat_exp;
    int          n;
    logic        got;
    exp     = model(o, x, y);
    lat_exp = model_latency(o, x, y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    n     = 0;
    got   = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1 && lat_exp > 1) check32({tag, ".busy"}, 32'(busy), 32'd1);
      if (mult_ok) got = 1'b1;
    end
    check32({tag, ".latency"}, 32'(n), 32'(lat_exp));
    check32({tag, ".hi"}, hi, exp[63:32]);
    check32({tag, ".lo"}, lo, exp[31:0]);
    $display("op %s: %s a=%h b=%h -> hi=%h lo=%h after %0d cycles", tag, o.name(), x, y, hi, lo, n);
    last_exp = exp;
    start = 1'b0;
    ack   = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
    check32({tag, ".idle_ok"}, 32'(mult_ok), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] exp;
    logic        seen_ok;
    int          n;
    logic [31:0] ra;
    logic [31:0] rb;
    muldiv_op_t  ro;

    reset = 1'b1;
    start = 1'b0;
    op    = OP_MULT;
    a     = '0;
    b     = '0;
    ack   = 1'b0;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check32("reset.hi", hi, 32'd0);
    check32("reset.lo", lo, 32'd0);
    check32("reset.mult_ok", 32'(mult_ok), 32'd0);
    check32("reset.busy", 32'(busy), 32'd0);

    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3);
    run_op("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("divu", OP_DIVU, 32'd100, 32'd7);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_zero", OP_DIVU, 32'd5, 32'd0);
    run_op("div_zero_neg", OP_DIV, 32'hFFFF_FFF9, 32'd0);
    run_op("divu_small", OP_DIVU, 32'd3, 32'd10);
    run_op("div_small_neg", OP_DIV, 32'hFFFF_FFFD, 32'd10);

    // Exec stalled after DONE: start stays high, ack low.
    exp   = model(OP_MULT, 32'd1234, 32'hFFFF_0000);
    op    = OP_MULT;
    a     = 32'd1234;
    b     = 32'hFFFF_0000;
    start = 1'b1;
    n = 0;
    while (!mult_ok && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check32("stall.latency", 32'(n), 32'(MS + 1));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check32("stall.mult_ok", 32'(mult_ok), 32'd1);
      check32("stall.hi", hi, exp[63:32]);
      check32("stall.lo", lo, exp[31:0]);
    end
    $display("stall: held DONE 5 cycles hi=%h lo=%h", hi, lo);
    start = 1'b0;
    ack   = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
    check32("stall.release_ok", 32'(mult_ok), 32'd0);
    check32("stall.release_busy", 32'(busy), 32'd0);
    last_exp = exp;

    // Flush at T+10 of a full-length divide.
    op    = OP_DIVU;
    a     = 32'hDEAD_BEEF;
    b     = 32'd12345;
    start = 1'b1;
    @(posedge clk);
    #1;
    repeat (9) @(posedge clk);
    #1;
    check32("flush.busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check32("flush.busy", 32'(busy), 32'd0);
    check32("flush.mult_ok", 32'(mult_ok), 32'd0);
    check32("flush.hi", hi, last_exp[63:32]);
    check32("flush.lo", lo, last_exp[31:0]);
    seen_ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (mult_ok || busy) seen_ok = 1'b1;
    end
    check32("flush.stays_idle", 32'(seen_ok), 32'd0);
    $display("flush: divide aborted, hi=%h lo=%h", hi, lo);

    // start together with flush in IDLE is ignored.
    op    = OP_MULT;
    a     = 32'd7;
    b     = 32'd9;
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    check32("flush_start.busy", 32'(busy), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check32("flush_start.mult_ok", 32'(mult_ok), 32'd0);
    $display("flush+start: ignored");

    // Asynchronous reset at T+5 of a multiply (result already present).
    op    = OP_MULT;
    a     = 32'h1234_5678;
    b     = 32'h0000_0100;
    start = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check32("rst_mul.pre_ok", 32'(mult_ok), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check32("rst_mul.hi", hi, 32'd0);
    check32("rst_mul.lo", lo, 32'd0);
    check32("rst_mul.mult_ok", 32'(mult_ok), 32'd0);
    check32("rst_mul.busy", 32'(busy), 32'd0);
    start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    $display("reset mid-mul: outputs cleared");

    // Asynchronous reset in the middle of a divide.
    op    = OP_DIV;
    a     = 32'h8765_4321;
    b     = 32'd3;
    start = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b0;
    check32("rst_div.pre_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check32("rst_div.busy", 32'(busy), 32'd0);
    check32("rst_div.mult_ok", 32'(mult_ok), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    $display("reset mid-div: outputs cleared");

    for (int i = 0; i < 24; i++) begin
      ro = muldiv_op_t'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 20);
        2: ra = $urandom_range(0, 9);
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op($sformatf("rand%0d", i), ro, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
